// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the AES-128 key schedule.
// Optional RK_VALID output is enabled with AES_KS_RKVALID_EN.
package aes_pkg;

  localparam int NR = 10;
  localparam int NK = 4;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ks_state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant for a round index; zero outside 1..10.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = '0;
    for (int i = 1; i <= NR; i++) begin
      if (r == 4'(i)) v = RCON[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, 256-entry lookup table.
// Part of aes_key_schedule (optional feature macro AES_KS_RKVALID_EN).
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_y = SBOX[i_a];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock, RK0..RK10.
// Define AES_KS_RKVALID_EN to add the per-key RK_VALID output.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          KE_START,
  input  logic [127:0]  CIPHER_KEY,
  output logic [1407:0] KEY_SCHEDULE,
  output logic          KE_BUSY,
  output logic          KE_DONE
`ifdef AES_KS_RKVALID_EN
  ,
  output logic [10:0]   RK_VALID
`endif
);

  ks_state_t r_state;
  ks_state_t w_state_nxt;
  logic [3:0] r_rnd;
  rkey_t      r_rk [0:NR];
  logic       r_busy;
  logic       r_done;

  logic  w_load;
  logic  w_step;
  logic  w_last;
  rkey_t w_prev;
  rkey_t w_next;
  word_t w_p [NK];
  word_t w_n [NK];
  word_t w_rot;
  word_t w_sub;
  word_t w_t;

  assign w_last = (r_rnd == 4'(NR));

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // KE_START is only honoured outside EXPAND.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (KE_START) begin
          w_load      = 1'b1;
          w_state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_prev = '0;
    for (int k = 1; k <= NR; k++) begin
      if (r_rnd == 4'(k)) w_prev = r_rk[k-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NK; i++) begin
      w_p[i] = w_prev[127-32*i -: 32];
    end
  end

  assign w_rot = rot_word(w_p[NK-1]);

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .i_a (w_rot[8*g +: 8]),
      .o_y (w_sub[8*g +: 8])
    );
  end

  assign w_t = w_sub ^ {rcon_of(r_rnd), 24'h0};

  always_comb begin
    w_n[0] = w_p[0] ^ w_t;
    for (int i = 1; i < NK; i++) begin
      w_n[i] = w_p[i] ^ w_n[i-1];
    end
  end

  assign w_next = {w_n[0], w_n[1], w_n[2], w_n[3]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k <= NR; k++) r_rk[k] <= '0;
      r_rnd  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_step && w_last;
      if (w_load) begin
        r_rk[0] <= CIPHER_KEY;
        r_rnd   <= 4'd1;
        r_busy  <= 1'b1;
      end else if (w_step) begin
        for (int k = 1; k <= NR; k++) begin
          if (r_rnd == 4'(k)) r_rk[k] <= w_next;
        end
        r_rnd <= w_last ? 4'd0 : r_rnd + 4'd1;
        if (w_last) r_busy <= 1'b0;
      end
    end
  end

`ifdef AES_KS_RKVALID_EN
  logic [10:0] r_vld;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_vld <= '0;
    end else if (w_load) begin
      r_vld <= 11'h001;
    end else if (w_step) begin
      r_vld <= r_vld | (11'h001 << r_rnd);
    end
  end

  assign RK_VALID = r_vld;
`endif

  for (genvar k = 0; k <= NR; k++) begin : g_out
    assign KEY_SCHEDULE[128*k +: 128] = r_rk[k];
  end

  assign KE_BUSY = r_busy;
  assign KE_DONE = r_done;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed-vector bench for aes_key_schedule using FIPS-197 keys.
// Covers RK_VALID when AES_KS_RKVALID_EN is defined.
module tb_aes_key_schedule;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          KE_START;
  logic [127:0]  CIPHER_KEY;
  logic [1407:0] KEY_SCHEDULE;
  logic          KE_BUSY;
  logic          KE_DONE;
`ifdef AES_KS_RKVALID_EN
  logic [10:0]   RK_VALID;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] KA  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  always #5 CLK = ~CLK;

  aes_key_schedule dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .KE_START     (KE_START),
    .CIPHER_KEY   (CIPHER_KEY),
    .KEY_SCHEDULE (KEY_SCHEDULE),
    .KE_BUSY      (KE_BUSY),
    .KE_DONE      (KE_DONE)
`ifdef AES_KS_RKVALID_EN
    ,
    .RK_VALID     (RK_VALID)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] rk(input int k);
    return KEY_SCHEDULE[128*k +: 128];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [127:0] key);
    CIPHER_KEY = key;
    KE_START   = 1'b1;
    tick();
    KE_START   = 1'b0;
  endtask

  initial begin
    int n_done;
    int n_busy;

    RESET      = 1'b1;
    KE_START   = 1'b0;
    CIPHER_KEY = '0;
    tick();
    tick();
    chk("rst_busy", 128'(KE_BUSY), 128'd0);
    chk("rst_done", 128'(KE_DONE), 128'd0);
    chk("rst_ks", 128'(|KEY_SCHEDULE), 128'd0);
`ifdef AES_KS_RKVALID_EN
    chk("rst_vld", 128'(RK_VALID), 128'd0);
`endif
    RESET = 1'b0;
    tick();

    // FIPS-197 A.1 with a single-cycle start pulse
    start(KA);
    chk("a_rk0", rk(0), KA);
    chk("a_busy0", 128'(KE_BUSY), 128'd1);
    chk("a_done0", 128'(KE_DONE), 128'd0);
`ifdef AES_KS_RKVALID_EN
    chk("a_vld0", 128'(RK_VALID), 128'h001);
`endif
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("a_busy%0d", k), 128'(KE_BUSY), 128'd1);
      chk($sformatf("a_done%0d", k), 128'(KE_DONE), 128'd0);
`ifdef AES_KS_RKVALID_EN
      chk($sformatf("a_vld%0d", k), 128'(RK_VALID),
          128'((1 << (k + 1)) - 1));
`endif
      if (k == 1) chk("a_rk1", rk(1), A1);
      if (k == 2) chk("a_rk2", rk(2), A2);
    end
    tick();
    chk("a_done10", 128'(KE_DONE), 128'd1);
    chk("a_busy10", 128'(KE_BUSY), 128'd0);
    chk("a_rk10", rk(10), A10);
`ifdef AES_KS_RKVALID_EN
    chk("a_vld10", 128'(RK_VALID), 128'h7ff);
`endif
    tick();
    chk("a_done11", 128'(KE_DONE), 128'd0);
    chk("a_hold1", rk(1), A1);

    // FIPS-197 C.1
    start(KC);
    chk("c_rk0", rk(0), KC);
`ifdef AES_KS_RKVALID_EN
    chk("c_vld0", 128'(RK_VALID), 128'h001);
`endif
    for (int k = 1; k <= 10; k++) tick();
    chk("c_done", 128'(KE_DONE), 128'd1);
    chk("c_rk1", rk(1), C1);
    chk("c_rk10", rk(10), C10);

    // KE_START held high through E0..E10, restarting from DONE
    n_done     = 0;
    n_busy     = 0;
    CIPHER_KEY = KA;
    KE_START   = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (KE_DONE) n_done++;
      if (KE_BUSY) n_busy++;
    end
    KE_START = 1'b0;
    chk("h_done_at10", 128'(KE_DONE), 128'd1);
    tick();
    if (KE_DONE) n_done++;
    chk("h_ndone", 128'(n_done), 128'd1);
    chk("h_nbusy", 128'(n_busy), 128'd10);
    chk("h_rk0", rk(0), KA);
    chk("h_rk1", rk(1), A1);
    chk("h_rk10", rk(10), A10);

    // Key input changes mid-run
    start(KA);
    tick();
    tick();
    CIPHER_KEY = '1;
    for (int k = 3; k <= 10; k++) tick();
    chk("k_done", 128'(KE_DONE), 128'd1);
    chk("k_rk0", rk(0), KA);
    chk("k_rk1", rk(1), A1);
    chk("k_rk10", rk(10), A10);

    // Reset at E5 of a run
    start(KC);
    for (int k = 1; k <= 4; k++) tick();
    RESET = 1'b1;
    tick();
    chk("r_ks", 128'(|KEY_SCHEDULE), 128'd0);
    chk("r_busy", 128'(KE_BUSY), 128'd0);
    chk("r_done", 128'(KE_DONE), 128'd0);
`ifdef AES_KS_RKVALID_EN
    chk("r_vld", 128'(RK_VALID), 128'd0);
`endif
    // Reset wins over a simultaneous start
    KE_START = 1'b1;
    tick();
    KE_START = 1'b0;
    RESET    = 1'b0;
    chk("r_start_busy", 128'(KE_BUSY), 128'd0);
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (KE_DONE) n_done++;
    end
    chk("r_nodone", 128'(n_done), 128'd0);

    start(KA);
    for (int k = 1; k <= 10; k++) tick();
    chk("n_done", 128'(KE_DONE), 128'd1);
    chk("n_rk1", rk(1), A1);
    chk("n_rk10", rk(10), A10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
